// File: rtl/fb_writer.sv
// Framebuffer write stage: takes shaded pixels over valid/ready, writes them into the
// current bank of a double-buffered BRAM and swaps banks in vertical blanking once a frame is full.
module fb_writer #(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int H_BITS    = 10,
    parameter int V_BITS    = 10,
    parameter int ADDR_BITS = 17
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 px_valid_in,
    output logic                 px_ready_out,
    input  logic [H_BITS-1:0]    px_h_in,
    input  logic [V_BITS-1:0]    px_v_in,
    input  logic [3:0]           px_color_in,
    input  logic                 vblank_in,
    output logic                 we_out,
    output logic [ADDR_BITS-1:0] waddr_out,
    output logic [3:0]           wdata_out,
    output logic                 wbank_out,
    output logic                 dbank_out,
    output logic                 frame_done_out,
    output logic                 drop_out
);

    localparam int NUM_PX   = WIDTH * HEIGHT;
    localparam int CNT_BITS = $clog2(NUM_PX + 1);

    localparam logic ST_FILL        = 1'b0;
    localparam logic ST_WAIT_VBLANK = 1'b1;

    logic                 state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [3:0]           wdata_q, wdata_d;
    logic                 wbank_q, wbank_d;
    logic                 done_q, done_d;
    logic                 drop_q, drop_d;

    logic accept;
    logic in_range;
    logic last_px;

    assign px_ready_out = (state_q == ST_FILL) & ~rst_in;
    assign accept       = px_valid_in & px_ready_out;
    assign in_range     = (int'(px_h_in) < WIDTH) && (int'(px_v_in) < HEIGHT);
    assign last_px      = (cnt_q == CNT_BITS'(NUM_PX - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        drop_d  = 1'b0;
        done_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wbank_d = wbank_q;

        if (accept) begin
            if (in_range) begin
                we_d    = 1'b1;
                // Exact for in-range pixels because 2^ADDR_BITS covers the whole frame.
                waddr_d = ADDR_BITS'(px_v_in) * ADDR_BITS'(WIDTH) + ADDR_BITS'(px_h_in);
                wdata_d = px_color_in;
                cnt_d   = cnt_q + CNT_BITS'(1);
                if (last_px) begin
                    state_d = ST_WAIT_VBLANK;
                end
            end else begin
                drop_d = 1'b1;
            end
        end

        if (state_q == ST_WAIT_VBLANK && vblank_in) begin
            wbank_d = ~wbank_q;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbank_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wbank_q <= wbank_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign we_out         = we_q;
    assign waddr_out      = waddr_q;
    assign wdata_out      = wdata_q;
    assign wbank_out      = wbank_q;
    assign dbank_out      = ~wbank_q;
    assign frame_done_out = done_q;
    assign drop_out       = drop_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: a 4x3 instance for frame/bank behaviour and a
// default-size instance for address arithmetic.
module tb_fb_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4x3 instance
    logic       valid = 1'b0;
    logic       ready;
    logic [9:0] h = '0;
    logic [9:0] v = '0;
    logic [3:0] color = '0;
    logic       vblank = 1'b0;
    logic       we;
    logic [3:0] waddr;
    logic [3:0] wdata;
    logic       wbank, dbank, done, drop;

    // default 320x240 instance
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [9:0]  d_h = '0;
    logic [9:0]  d_v = '0;
    logic [3:0]  d_color = '0;
    logic        d_we;
    logic [16:0] d_waddr;
    logic [3:0]  d_wdata;
    logic        d_wbank, d_dbank, d_done, d_drop;

    int n_checks = 0;
    int n_pass   = 0;

    fb_writer #(
        .WIDTH    (4),
        .HEIGHT   (3),
        .H_BITS   (10),
        .V_BITS   (10),
        .ADDR_BITS(4)
    ) u_dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .px_valid_in   (valid),
        .px_ready_out  (ready),
        .px_h_in       (h),
        .px_v_in       (v),
        .px_color_in   (color),
        .vblank_in     (vblank),
        .we_out        (we),
        .waddr_out     (waddr),
        .wdata_out     (wdata),
        .wbank_out     (wbank),
        .dbank_out     (dbank),
        .frame_done_out(done),
        .drop_out      (drop)
    );

    fb_writer u_dut_def (
        .clk_in        (clk),
        .rst_in        (rst),
        .px_valid_in   (d_valid),
        .px_ready_out  (d_ready),
        .px_h_in       (d_h),
        .px_v_in       (d_v),
        .px_color_in   (d_color),
        .vblank_in     (1'b0),
        .we_out        (d_we),
        .waddr_out     (d_waddr),
        .wdata_out     (d_wdata),
        .wbank_out     (d_wbank),
        .dbank_out     (d_dbank),
        .frame_done_out(d_done),
        .drop_out      (d_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int idx, input logic [3:0] c);
        valid = 1'b1;
        h     = 10'(idx % 4);
        v     = 10'(idx / 4);
        color = c;
    endtask

    initial begin
        // Reset held for 3 cycles with valid asserted
        valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ready", ready, 0);
            check("rst_we", we, 0);
            check("rst_wbank", wbank, 0);
            check("rst_dbank", dbank, 1);
        end
        check("rst_drop", drop, 0);
        check("rst_done", done, 0);
        check("rst_waddr", waddr, 0);
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        check("rel_ready", ready, 1);

        // Single write on default geometry: 2*320+5 = 645
        d_valid = 1'b1; d_h = 10'd5; d_v = 10'd2; d_color = 4'hA;
        step();
        check("def_we", d_we, 1);
        check("def_waddr", d_waddr, 645);
        check("def_wdata", d_wdata, 4'hA);
        check("def_wbank", d_wbank, 0);
        d_valid = 1'b0;
        step();
        check("def_we_pulse", d_we, 0);

        // Full frame, back to back, into bank 0
        for (int i = 0; i < 12; i++) begin
            set_px(i, 4'(i));
            step();
            check("f1_we", we, 1);
            check("f1_waddr", waddr, i);
            check("f1_wdata", wdata, i & 15);
            check("f1_wbank", wbank, 0);
            check("f1_ready", ready, (i < 11) ? 1 : 0);
        end
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("f1_hold_ready", ready, 0);
            check("f1_hold_we", we, 0);
        end
        vblank = 1'b1;
        step();
        check("swap1_done", done, 1);
        check("swap1_wbank", wbank, 1);
        check("swap1_dbank", dbank, 0);
        check("swap1_ready", ready, 1);
        vblank = 1'b0;
        step();
        check("swap1_done_pulse", done, 0);

        // Two out-of-range pixels are dropped and not counted
        valid = 1'b1; h = 10'd4; v = 10'd0; color = 4'hF;
        step();
        check("oor_h_drop", drop, 1);
        check("oor_h_we", we, 0);
        h = 10'd0; v = 10'd3;
        step();
        check("oor_v_drop", drop, 1);
        check("oor_v_we", we, 0);

        // 12 in-range pixels into bank 1, vblank pulsed mid-frame has no effect
        for (int i = 0; i < 12; i++) begin
            set_px(i, 4'(15 - i));
            vblank = (i >= 5 && i < 8);
            step();
            check("f2_we", we, 1);
            check("f2_drop", drop, 0);
            check("f2_waddr", waddr, i);
            check("f2_wbank", wbank, 1);
            check("f2_done", done, 0);
            check("f2_ready", ready, (i < 11) ? 1 : 0);
        end
        vblank = 1'b0;

        // Backpressure: pixel (1,1) held until the swap has happened
        valid = 1'b1; h = 10'd1; v = 10'd1; color = 4'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ready", ready, 0);
            check("bp_we", we, 0);
        end
        vblank = 1'b1;
        step();
        check("swap2_done", done, 1);
        check("swap2_wbank", wbank, 0);
        check("swap2_dbank", dbank, 1);
        check("swap2_ready", ready, 1);
        check("swap2_we", we, 0);
        vblank = 1'b0;
        step();
        check("bp_wr_we", we, 1);
        check("bp_wr_waddr", waddr, 5);
        check("bp_wr_wdata", wdata, 4'h3);
        check("bp_wr_wbank", wbank, 0);
        check("bp_done_pulse", done, 0);

        // Reach 7 pixels, then reset mid-frame
        for (int i = 0; i < 6; i++) begin
            set_px(i, 4'h7);
            step();
        end
        rst = 1'b1;
        step();
        check("mrst_ready", ready, 0);
        check("mrst_we", we, 0);
        check("mrst_wbank", wbank, 0);
        check("mrst_dbank", dbank, 1);
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        check("mrst_rel_ready", ready, 1);

        // A full 12 fresh pixels are needed before ready drops
        for (int i = 0; i < 12; i++) begin
            set_px(i, 4'h1);
            step();
            check("f3_waddr", waddr, i);
            check("f3_ready", ready, (i < 11) ? 1 : 0);
        end
        valid = 1'b0;
        step();
        check("f3_end_ready", ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
